// File: rtl/spi_stream_reader_if.sv
// SPI pin bundle plus FIFO read port for the audio stream reader.
// The slave modport is the reader's view; master is the host/FIFO side.
interface spi_stream_reader_if #(
    parameter int COUNT_WIDTH = 17
) ();
    logic                   sck;
    logic                   cs;
    logic                   mosi;
    logic                   miso;
    logic                   fifo_rd_en;
    logic [7:0]             fifo_rd_data;
    logic                   fifo_empty;
    logic [COUNT_WIDTH-1:0] fifo_count;
    logic                   busy;
    logic                   underflow;

    modport slave (
        input  sck,
        input  cs,
        input  mosi,
        output miso,
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        input  fifo_count,
        output busy,
        output underflow
    );

    modport master (
        output sck,
        output cs,
        output mosi,
        input  miso,
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        output fifo_count,
        input  busy,
        input  underflow
    );
endinterface

// File: rtl/spi_stream_reader.sv
// SPI mode-0 slave that drains the compressed-audio byte FIFO to the host.
// One command byte per transaction selects streaming, fill-count readout,
// underflow clear or discard; status is returned during the command byte.
module spi_stream_reader #(
    parameter int         COUNT_WIDTH = 17,
    parameter logic [7:0] FILL_BYTE   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_stream_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, STREAM, COUNT, DISCARD} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev, cs_prev;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;

    logic [2:0]  bit_cnt;
    logic        boundary;
    logic [6:0]  rx_sh;
    logic [7:0]  rx_byte;
    logic [7:0]  shreg;

    logic        rd_en_q, cap_q, rd_issue;
    logic        stg_full;
    logic [7:0]  stg;
    logic [7:0]  cur_byte;
    logic        inflight, pend, fill_pend;
    logic        underflow_q, uf_set;

    logic [23:0] cnt_ext;
    logic [15:0] cnt_lo;
    logic [1:0]  cnt_idx;
    logic [7:0]  count_byte;
    logic [7:0]  stream_byte;

    logic        load_status, load_stream, load_count, load_zero;
    logic        latch_cnt, clr_uf;
    logic        use_pend, use_cap, use_stg, use_fill;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    assign boundary = sck_rise && (bit_cnt == 3'd7);
    assign rx_byte  = {rx_sh, mosi_s};
    assign cnt_ext  = 24'(bus.fifo_count);

    assign bus.miso       = (state != IDLE) & shreg[7];
    assign bus.busy       = (state != IDLE);
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.underflow  = underflow_q;

    // Synchronizers reset low so a falling cs is only seen after cs was high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync[0]  <= bus.sck;
            cs_sync[0]   <= bus.cs;
            mosi_sync[0] <= bus.mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync[i]  <= sck_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and per-byte load decisions; cs rising overrides everything.
    always_comb begin
        state_nx    = state;
        load_status = 1'b0;
        load_stream = 1'b0;
        load_count  = 1'b0;
        load_zero   = 1'b0;
        latch_cnt   = 1'b0;
        clr_uf      = 1'b0;
        if (cs_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nx    = CMD;
                        load_status = 1'b1;
                    end
                end
                CMD: begin
                    if (boundary) begin
                        case (rx_byte)
                            8'h01: begin
                                state_nx    = STREAM;
                                load_stream = 1'b1;
                            end
                            8'h02: begin
                                state_nx   = COUNT;
                                load_count = 1'b1;
                                latch_cnt  = 1'b1;
                            end
                            8'h03: begin
                                state_nx  = DISCARD;
                                load_zero = 1'b1;
                                clr_uf    = 1'b1;
                            end
                            default: begin
                                state_nx  = DISCARD;
                                load_zero = 1'b1;
                            end
                        endcase
                    end
                end
                STREAM:  if (boundary) load_stream = 1'b1;
                COUNT:   if (boundary) load_count = 1'b1;
                DISCARD: if (boundary) load_zero = 1'b1;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Source priority for the next streamed byte: interrupted byte, fresh capture, staging, fill.
    always_comb begin
        use_pend    = load_stream & pend;
        use_cap     = load_stream & ~pend & cap_q;
        use_stg     = load_stream & ~pend & ~cap_q & stg_full;
        use_fill    = load_stream & ~pend & ~cap_q & ~stg_full;
        stream_byte = FILL_BYTE;
        if (pend)          stream_byte = cur_byte;
        else if (cap_q)    stream_byte = bus.fifo_rd_data;
        else if (stg_full) stream_byte = stg;
        count_byte = 8'h00;
        if (latch_cnt) count_byte = cnt_ext[23:16];
        else if (cnt_idx == 2'd1) count_byte = cnt_lo[15:8];
        else if (cnt_idx == 2'd2) count_byte = cnt_lo[7:0];
        rd_issue = ((state == CMD) || (state == STREAM)) && !stg_full &&
                   !bus.fifo_empty && !rd_en_q && !cap_q;
        uf_set   = fill_pend & sck_rise & ~cs_rise;
    end

    // Bit counter: cleared at every cs edge, wraps 7->0 at the byte boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              bit_cnt <= 3'd0;
        else if (cs_fall || cs_rise)             bit_cnt <= 3'd0;
        else if (sck_rise && (state != IDLE))    bit_cnt <= bit_cnt + 3'd1;
    end

    // Receive and transmit shifters; no shift on the fall following a fresh load.
    always_ff @(posedge clk) begin
        if (sck_rise) rx_sh <= rx_byte[6:0];
        if (load_status)      shreg <= {bus.fifo_empty, underflow_q, 6'b0};
        else if (load_stream) shreg <= stream_byte;
        else if (load_count)  shreg <= count_byte;
        else if (load_zero)   shreg <= 8'h00;
        else if (sck_fall && (bit_cnt != 3'd0) && (state != IDLE))
            shreg <= {shreg[6:0], 1'b0};
    end

    // Prefetch handshake, staging occupancy and interrupted-byte bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q   <= 1'b0;
            cap_q     <= 1'b0;
            stg_full  <= 1'b0;
            inflight  <= 1'b0;
            pend      <= 1'b0;
            fill_pend <= 1'b0;
            cnt_idx   <= 2'd0;
        end else begin
            rd_en_q <= rd_issue;
            cap_q   <= rd_en_q;
            if (cap_q && !use_cap) stg_full <= 1'b1;
            else if (use_stg)      stg_full <= 1'b0;
            if (cs_rise) begin
                inflight  <= 1'b0;
                fill_pend <= 1'b0;
                if (inflight) pend <= 1'b1;
            end else begin
                if (load_stream) begin
                    inflight  <= ~use_fill;
                    fill_pend <= use_fill;
                end else if (uf_set) begin
                    fill_pend <= 1'b0;
                end
                if (use_pend) pend <= 1'b0;
            end
            if (latch_cnt)                         cnt_idx <= 2'd1;
            else if (load_count && cnt_idx != 2'd3) cnt_idx <= cnt_idx + 2'd1;
        end
    end

    // Data holding registers for staged, in-flight and latched-count bytes.
    always_ff @(posedge clk) begin
        if (cap_q && !use_cap) stg <= bus.fifo_rd_data;
        if (use_cap)           cur_byte <= bus.fifo_rd_data;
        else if (use_stg)      cur_byte <= stg;
        if (latch_cnt)         cnt_lo <= cnt_ext[15:0];
    end

    // Sticky underflow: raised when the host clocks the first bit of a fill byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_q <= 1'b0;
        end else begin
            if (clr_uf) underflow_q <= 1'b0;
            if (uf_set) underflow_q <= 1'b1;
        end
    end
endmodule
